// File: rtl/qqspi_pkg.sv
// qqspi_pkg: definitions shared by the qqspi host and the qqspi responder.
//   - Command opcodes (PSRAM-style quad commands and plain SPI commands).
//   - The responder state encoding.
package qqspi_pkg;

    localparam logic [7:0] CMD_QUAD_WRITE     = 8'h38;
    localparam logic [7:0] CMD_FAST_READ_QUAD = 8'hEB;
    localparam logic [7:0] CMD_WRITE          = 8'h02;
    localparam logic [7:0] CMD_READ           = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WAIT,
        ST_RDATA,
        ST_WDATA,
        ST_IGNORE
    } qqspi_state_t;

endpackage

// File: rtl/qqspi_pin_sync.sv
// qqspi_pin_sync: brings the asynchronous host pins into the clk domain.
// Ports:
//   clk, resetn          responder clock, synchronous active-high reset
//   sclk, cen, cs        raw host pins
//   cen_s, cs_s          2-FF synchronized chip enable and bank select
//   sclk_rise, sclk_fall one-clk pulses on edges of the synchronized sclk
module qqspi_pin_sync (
    input  logic       clk,
    input  logic       resetn,
    input  logic       sclk,
    input  logic       cen,
    input  logic [1:0] cs,
    output logic       cen_s,
    output logic [1:0] cs_s,
    output logic       sclk_rise,
    output logic       sclk_fall
);

    logic [1:0] sclk_ff;
    logic [1:0] cen_ff;
    logic [1:0] cs_ff0;
    logic [1:0] cs_ff1;
    logic       sclk_prev;

    always_ff @(posedge clk) begin
        if (resetn) begin
            sclk_ff   <= '0;
            cen_ff    <= '0;
            cs_ff0    <= '0;
            cs_ff1    <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_ff   <= {sclk_ff[0], sclk};
            cen_ff    <= {cen_ff[0], cen};
            cs_ff0    <= cs;
            cs_ff1    <= cs_ff0;
            sclk_prev <= sclk_ff[1];
        end
    end

    assign cen_s     = cen_ff[1];
    assign cs_s      = cs_ff1;
    // Edge pulses are combinational from the second stage so that the
    // consuming register acts on the third clk after the pad edge.
    assign sclk_rise = sclk_ff[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_ff[1] & sclk_prev;

endmodule

// File: rtl/qqspi_responder.sv
// qqspi_responder: device side of the qqspi protocol (PSRAM emulation).
// Decodes command/address/data from the oversampled host pins and drives a
// byte-wide synchronous memory port (read data valid the clk after mem_re).
// Ports:
//   clk, resetn              responder clock, synchronous active-high reset
//   sclk, cen, cs            host pins (asynchronous)
//   sio_in/sio_out/sio_oe    pad data in, pad data out, pad output enables
//   mem_addr/mem_wdata       memory byte address and write byte
//   mem_we/mem_re            one-clk write / read strobes
//   mem_rdata                memory read byte
module qqspi_responder
    import qqspi_pkg::*;
#(
    parameter bit         QUAD_MODE   = 1'b1,
    parameter bit         CEN_NPOL    = 1'b0,
    parameter logic [1:0] CS_ID       = 2'b00,
    parameter int         WAIT_CYCLES = 6
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sclk,
    input  logic        cen,
    input  logic [1:0]  cs,
    input  logic [3:0]  sio_in,
    output logic [3:0]  sio_out,
    output logic [3:0]  sio_oe,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata
);

    localparam logic [5:0] ADDR_LAST = QUAD_MODE ? 6'd5 : 6'd23;
    localparam logic [5:0] BYTE_LAST = QUAD_MODE ? 6'd1 : 6'd7;
    localparam logic [2:0] TX_LAST   = QUAD_MODE ? 3'd1 : 3'd7;
    localparam logic [5:0] WAIT_LAST = 6'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [3:0] OE_MASK   = QUAD_MODE ? 4'b1111 : 4'b0010;
    localparam logic [7:0] OP_WRITE  = QUAD_MODE ? CMD_QUAD_WRITE : CMD_WRITE;
    localparam logic [7:0] OP_READ   = QUAD_MODE ? CMD_FAST_READ_QUAD : CMD_READ;
    localparam qqspi_state_t READ_ENTRY =
        (QUAD_MODE && WAIT_CYCLES > 0) ? ST_WAIT : ST_RDATA;

    logic         cen_s;
    logic [1:0]   cs_s;
    logic         sclk_rise;
    logic         sclk_fall;

    qqspi_state_t state;
    logic [5:0]   cnt;
    logic [2:0]   tx_cnt;
    logic [7:0]   cmd_sh;
    logic [23:0]  addr;
    logic         is_write;
    logic         sel_prev;
    logic         fetch_pending;
    logic [7:0]   rd_buf;
    logic [7:0]   rd_sh;
    logic [7:0]   wr_sh;

    logic         sel;
    logic [7:0]   cmd_next;
    logic [23:0]  addr_next;
    logic [7:0]   wr_next;
    logic [7:0]   tx_src;

    qqspi_pin_sync u_sync (
        .clk       (clk),
        .resetn    (resetn),
        .sclk      (sclk),
        .cen       (cen),
        .cs        (cs),
        .cen_s     (cen_s),
        .cs_s      (cs_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    assign sel       = (cen_s ^ CEN_NPOL) == 1'b0;
    assign cmd_next  = {cmd_sh[6:0], sio_in[0]};
    assign addr_next = QUAD_MODE ? {addr[19:0], sio_in} : {addr[22:0], sio_in[0]};
    assign wr_next   = QUAD_MODE ? {wr_sh[3:0], sio_in} : {wr_sh[6:0], sio_in[0]};
    // The first drive of each byte comes from the prefetched buffer; the rest
    // of the byte is shifted out of rd_sh.
    assign tx_src    = (tx_cnt == 3'd0) ? rd_buf : rd_sh;

    // Main protocol FSM. Deselect is checked before any sclk edge so that an
    // edge arriving in the same clk as deselect is dropped. sel_prev resets
    // to 1 so a select already active when reset releases is not an edge.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            tx_cnt        <= '0;
            cmd_sh        <= '0;
            addr          <= '0;
            is_write      <= 1'b0;
            sel_prev      <= 1'b1;
            fetch_pending <= 1'b0;
            rd_buf        <= '0;
            rd_sh         <= '0;
            wr_sh         <= '0;
            sio_out       <= '0;
            sio_oe        <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            mem_re        <= 1'b0;
        end else begin
            mem_we        <= 1'b0;
            mem_re        <= 1'b0;
            sel_prev      <= sel;
            fetch_pending <= mem_re;
            if (fetch_pending) begin
                rd_buf <= mem_rdata;
            end

            if (state != ST_IDLE && !sel) begin
                state         <= ST_IDLE;
                sio_oe        <= '0;
                fetch_pending <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sel && !sel_prev && cs_s == CS_ID) begin
                            state  <= ST_CMD;
                            cnt    <= '0;
                            tx_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_sh <= cmd_next;
                            if (cnt == 6'd7) begin
                                cnt <= '0;
                                if (cmd_next == OP_WRITE) begin
                                    is_write <= 1'b1;
                                    state    <= ST_ADDR;
                                end else if (cmd_next == OP_READ) begin
                                    is_write <= 1'b0;
                                    state    <= ST_ADDR;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end else begin
                                cnt <= cnt + 6'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            addr <= addr_next;
                            if (cnt == ADDR_LAST) begin
                                cnt <= '0;
                                if (is_write) begin
                                    state <= ST_WDATA;
                                end else begin
                                    mem_re   <= 1'b1;
                                    mem_addr <= addr_next;
                                    state    <= READ_ENTRY;
                                end
                            end else begin
                                cnt <= cnt + 6'd1;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (sclk_rise) begin
                            if (cnt == WAIT_LAST) begin
                                cnt   <= '0;
                                state <= ST_RDATA;
                            end else begin
                                cnt <= cnt + 6'd1;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (sclk_rise) begin
                            if (cnt == BYTE_LAST) begin
                                cnt      <= '0;
                                addr     <= addr + 24'd1;
                                mem_re   <= 1'b1;
                                mem_addr <= addr + 24'd1;
                            end else begin
                                cnt <= cnt + 6'd1;
                            end
                        end
                        if (sclk_fall) begin
                            sio_oe <= OE_MASK;
                            if (QUAD_MODE) begin
                                sio_out <= tx_src[7:4];
                                rd_sh   <= {tx_src[3:0], 4'b0000};
                            end else begin
                                sio_out <= {2'b00, tx_src[7], 1'b0};
                                rd_sh   <= {tx_src[6:0], 1'b0};
                            end
                            tx_cnt <= (tx_cnt == TX_LAST) ? 3'd0 : tx_cnt + 3'd1;
                        end
                    end
                    ST_WDATA: begin
                        if (sclk_rise) begin
                            wr_sh <= wr_next;
                            if (cnt == BYTE_LAST) begin
                                cnt       <= '0;
                                mem_we    <= 1'b1;
                                mem_wdata <= wr_next;
                                mem_addr  <= addr;
                                addr      <= addr + 24'd1;
                            end else begin
                                cnt <= cnt + 6'd1;
                            end
                        end
                    end
                    ST_IGNORE: begin
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qqspi_responder.sv
// tb_qqspi_responder: bench for qqspi_responder. A quad instance and a
// single-bit instance share the host pins; each sees the other's opcodes as
// unknown and ignores them. Each instance has its own BRAM model, and a
// separate reference memory tracks what each should contain.
module tb_qqspi_responder;

    localparam int HALF = 40;

    logic        clk;
    logic        resetn;
    logic        sclk;
    logic        cen;
    logic [1:0]  cs;
    logic [3:0]  sio_in;

    logic [3:0]  sio_out_q, sio_oe_q, sio_out_s, sio_oe_s;
    logic [23:0] mem_addr_q, mem_addr_s;
    logic [7:0]  mem_wdata_q, mem_wdata_s, mem_rdata_q, mem_rdata_s;
    logic        mem_we_q, mem_re_q, mem_we_s, mem_re_s;

    int tests = 0;
    int fails = 0;
    int we_cnt_q = 0, re_cnt_q = 0, we_cnt_s = 0, re_cnt_s = 0;

    logic [7:0] bram_q [int];
    logic [7:0] bram_s [int];
    logic [7:0] ref_q [int];
    logic [7:0] ref_s [int];

    qqspi_responder #(.QUAD_MODE(1'b1), .CEN_NPOL(1'b0), .CS_ID(2'b00), .WAIT_CYCLES(6)) dut_q (
        .clk(clk), .resetn(resetn), .sclk(sclk), .cen(cen), .cs(cs), .sio_in(sio_in),
        .sio_out(sio_out_q), .sio_oe(sio_oe_q), .mem_addr(mem_addr_q), .mem_wdata(mem_wdata_q),
        .mem_we(mem_we_q), .mem_re(mem_re_q), .mem_rdata(mem_rdata_q)
    );

    qqspi_responder #(.QUAD_MODE(1'b0), .CEN_NPOL(1'b0), .CS_ID(2'b00), .WAIT_CYCLES(6)) dut_s (
        .clk(clk), .resetn(resetn), .sclk(sclk), .cen(cen), .cs(cs), .sio_in(sio_in),
        .sio_out(sio_out_s), .sio_oe(sio_oe_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
        .mem_we(mem_we_s), .mem_re(mem_re_s), .mem_rdata(mem_rdata_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-up contents of both memories: an arbitrary address pattern.
    function automatic logic [7:0] init_byte(input int a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'h5C;
    endfunction

    function automatic logic [7:0] bram_byte(input bit quad, input int a);
        if (quad) return bram_q.exists(a) ? bram_q[a] : init_byte(a);
        return bram_s.exists(a) ? bram_s[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_byte(input bit quad, input int a);
        if (quad) return ref_q.exists(a) ? ref_q[a] : init_byte(a);
        return ref_s.exists(a) ? ref_s[a] : init_byte(a);
    endfunction

    // Synchronous BRAM models with one-clk read latency.
    always @(posedge clk) begin
        if (mem_we_q) begin
            bram_q[int'(mem_addr_q)] = mem_wdata_q;
            we_cnt_q++;
        end
        if (mem_re_q) begin
            mem_rdata_q <= bram_byte(1'b1, int'(mem_addr_q));
            re_cnt_q++;
        end
        if (mem_we_s) begin
            bram_s[int'(mem_addr_s)] = mem_wdata_s;
            we_cnt_s++;
        end
        if (mem_re_s) begin
            mem_rdata_s <= bram_byte(1'b0, int'(mem_addr_s));
            re_cnt_s++;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic begin_xfer(input logic [1:0] csv);
        @(posedge clk);
        #3;
        sclk = 1'b0;
        cs   = csv;
        cen  = 1'b0;
        #60;
    endtask

    task automatic end_xfer();
        #20;
        cen = 1'b1;
        #100;
    endtask

    // One sclk period: present data, sample the DUT just before the rising
    // edge, rise, then fall.
    task automatic step(input logic [3:0] din, input bit quad,
                        output logic [3:0] dout, output logic [3:0] oe);
        sio_in = din;
        #HALF;
        dout = quad ? sio_out_q : sio_out_s;
        oe   = quad ? sio_oe_q : sio_oe_s;
        sclk = 1'b1;
        #HALF;
        sclk = 1'b0;
    endtask

    task automatic send_cmd(input bit quad, input logic [7:0] op, input string tag);
        logic [3:0] d, oe;
        for (int i = 7; i >= 0; i--) begin
            step({3'b000, op[i]}, quad, d, oe);
        end
        check_output({tag, " oe in cmd"}, 32'(oe), 32'h0);
    endtask

    task automatic send_addr(input bit quad, input logic [23:0] a, input string tag);
        logic [3:0] d, oe;
        if (quad) begin
            for (int i = 5; i >= 0; i--) step(a[i*4 +: 4], quad, d, oe);
        end else begin
            for (int i = 23; i >= 0; i--) step({3'b000, a[i]}, quad, d, oe);
        end
        check_output({tag, " oe in addr"}, 32'(oe), 32'h0);
    endtask

    task automatic send_byte(input bit quad, input logic [7:0] b);
        logic [3:0] d, oe;
        if (quad) begin
            step(b[7:4], quad, d, oe);
            step(b[3:0], quad, d, oe);
        end else begin
            for (int i = 7; i >= 0; i--) step({3'b000, b[i]}, quad, d, oe);
        end
    endtask

    // Write nbytes of data (MSB byte first), then extra_steps of a partial
    // byte before deselect.
    task automatic do_write(input bit quad, input logic [23:0] addr, input logic [31:0] data,
                            input int nbytes, input int extra_steps, input string tag);
        logic [3:0] d, oe;
        logic [7:0] b;
        int we0;
        we0 = quad ? we_cnt_q : we_cnt_s;
        begin_xfer(2'b00);
        send_cmd(quad, quad ? 8'h38 : 8'h02, tag);
        send_addr(quad, addr, tag);
        for (int k = 0; k < nbytes; k++) begin
            b = data[31 - 8*k -: 8];
            send_byte(quad, b);
        end
        for (int e = 0; e < extra_steps; e++) step(4'($urandom), quad, d, oe);
        end_xfer();
        check_output({tag, " write strobes"}, 32'((quad ? we_cnt_q : we_cnt_s) - we0), 32'(nbytes));
        for (int k = 0; k < nbytes; k++) begin
            b = data[31 - 8*k -: 8];
            if (quad) ref_q[int'(addr + 24'(k))] = b;
            else      ref_s[int'(addr + 24'(k))] = b;
        end
        for (int k = 0; k < nbytes; k++) begin
            check_output($sformatf("%s mem byte %0d", tag, k),
                         32'(bram_byte(quad, int'(addr + 24'(k)))),
                         32'(ref_byte(quad, int'(addr + 24'(k)))));
        end
    endtask

    // Read n bytes; each byte is checked against the reference memory and the
    // first up-to-4 bytes are returned as a word.
    task automatic do_read(input bit quad, input logic [23:0] addr, input int n,
                           input string tag, output logic [31:0] word);
        logic [3:0] d, oe;
        logic [7:0] b;
        word = '0;
        begin_xfer(2'b00);
        send_cmd(quad, quad ? 8'hEB : 8'h03, tag);
        send_addr(quad, addr, tag);
        if (quad) begin
            for (int i = 0; i < 6; i++) begin
                step(4'($urandom), quad, d, oe);
                check_output($sformatf("%s oe wait %0d", tag, i), 32'(oe), 32'h0);
            end
        end
        for (int k = 0; k < n; k++) begin
            b = '0;
            for (int j = 0; j < (quad ? 2 : 8); j++) begin
                step(4'($urandom), quad, d, oe);
                b = quad ? {b[3:0], d} : {b[6:0], d[1]};
                if (j == 0) check_output($sformatf("%s oe data %0d", tag, k), 32'(oe),
                                         quad ? 32'hF : 32'h2);
            end
            if (k < 4) word = {word[23:0], b};
            check_output($sformatf("%s rbyte %0d", tag, k), 32'(b),
                         32'(ref_byte(quad, int'(addr + 24'(k)))));
        end
        end_xfer();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] word;
        logic [3:0]  d, oe;
        logic [23:0] ra;
        int          nb, we0q, we0s, re0q, re0s;

        resetn = 1'b1;
        sclk   = 1'b0;
        cen    = 1'b1;
        cs     = 2'b00;
        sio_in = 4'h0;
        repeat (4) @(posedge clk);
        #3;
        check_output("reset sio_oe", 32'(sio_oe_q), 32'h0);
        check_output("reset sio_out", 32'(sio_out_q), 32'h0);
        check_output("reset mem_we", 32'(mem_we_q), 32'h0);
        check_output("reset mem_re", 32'(mem_re_q), 32'h0);
        check_output("reset mem_addr", 32'(mem_addr_q), 32'h0);
        check_output("reset mem_wdata", 32'(mem_wdata_q), 32'h0);
        check_output("reset single sio_oe", 32'(sio_oe_s), 32'h0);
        resetn = 1'b0;
        #100;

        // Quad write then quad read of the same word.
        do_write(1'b1, 24'h000100, 32'hDEADBEEF, 4, 0, "qwrite");
        do_read(1'b1, 24'h000100, 4, "qread", word);
        check_output("qread word", word, 32'hDEADBEEF);

        // Single-bit write of one byte and a read covering it.
        do_write(1'b0, 24'h000003, 32'h5A000000, 1, 0, "swrite");
        do_read(1'b0, 24'h000000, 4, "sread", word);
        check_output("sread byte3", 32'(word[7:0]), 32'h5A);

        // Wrong bank select: nobody responds.
        we0q = we_cnt_q; we0s = we_cnt_s;
        begin_xfer(2'b01);
        send_cmd(1'b1, 8'h38, "cs01");
        send_addr(1'b1, 24'h000200, "cs01");
        for (int i = 0; i < 8; i++) step(4'($urandom), 1'b1, d, oe);
        check_output("cs01 oe", 32'(oe), 32'h0);
        end_xfer();
        check_output("cs01 quad strobes", 32'(we_cnt_q - we0q), 32'h0);
        check_output("cs01 single strobes", 32'(we_cnt_s - we0s), 32'h0);

        // Partial byte at the top of memory, then a read wrapping to 0.
        do_write(1'b1, 24'hFFFFFF, 32'h3C000000, 1, 1, "wrap write");
        check_output("wrap addr0 untouched", 32'(bram_byte(1'b1, 0)), 32'(ref_byte(1'b1, 0)));
        do_read(1'b1, 24'hFFFFFE, 4, "wrap read", word);

        // Reset in the middle of read data.
        begin_xfer(2'b00);
        send_cmd(1'b1, 8'hEB, "rst");
        send_addr(1'b1, 24'h000100, "rst");
        for (int i = 0; i < 8; i++) step(4'($urandom), 1'b1, d, oe);
        check_output("rst oe before", 32'(sio_oe_q), 32'hF);
        resetn = 1'b1;
        #10;
        check_output("rst oe after", 32'(sio_oe_q), 32'h0);
        resetn = 1'b0;
        re0q = re_cnt_q; we0q = we_cnt_q;
        for (int i = 0; i < 6; i++) step(4'($urandom), 1'b1, d, oe);
        check_output("rst no drive", 32'(oe), 32'h0);
        check_output("rst no strobes", 32'((re_cnt_q - re0q) + (we_cnt_q - we0q)), 32'h0);
        end_xfer();
        do_read(1'b1, 24'h000100, 4, "post rst read", word);
        check_output("post rst word", word, 32'hDEADBEEF);

        // Unknown opcode.
        we0q = we_cnt_q; we0s = we_cnt_s; re0q = re_cnt_q; re0s = re_cnt_s;
        begin_xfer(2'b00);
        send_cmd(1'b1, 8'h9F, "op9f");
        for (int i = 0; i < 12; i++) step(4'($urandom), 1'b1, d, oe);
        check_output("op9f oe", 32'(oe), 32'h0);
        check_output("op9f single oe", 32'(sio_oe_s), 32'h0);
        end_xfer();
        check_output("op9f strobes",
                     32'((we_cnt_q - we0q) + (we_cnt_s - we0s) + (re_cnt_q - re0q) + (re_cnt_s - re0s)),
                     32'h0);

        // Random writes with read-back around the written range.
        for (int it = 0; it < 8; it++) begin
            bit q;
            q  = 1'($urandom_range(0, 1));
            ra = 24'($urandom_range(1, 200));
            if (it == 3) ra = 24'hFFFFFD;
            case ($urandom_range(0, 2))
                0:       nb = 1;
                1:       nb = 2;
                default: nb = 4;
            endcase
            do_write(q, ra, $urandom, nb, 0, $sformatf("rnd%0d write", it));
            do_read(q, ra - 24'd1, nb + 2, $sformatf("rnd%0d read", it), word);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/qqspi_responder.md
# qqspi_responder

Synthesizable QSPI/SPI memory responder: the device side of the team's qqspi host protocol (PSRAM-style commands 0x38/0xEB/0x02/0x03). It oversamples the host's sclk/cen/cs on its own fast clock, decodes command, address and data, and services a byte-wide synchronous memory port (BRAM-backed). It is used for FPGA-side PSRAM emulation and as the bus-functional partner in qqspi benches.

## Interface

- QUAD_MODE, 1'b1: 1 = 0x38/0xEB with quad address/data; 0 = 0x02/0x03, all single-bit.
- CEN_NPOL, 1'b0: cen polarity; selected when (cen ^ CEN_NPOL) == 0.
- CS_ID, 2'b00: responds only when cs == CS_ID, sampled at the select edge.
- WAIT_CYCLES, 6: dummy sclk cycles after the address for 0xEB.
- clk  in  1  responder clock; ≥3× the host clock.
- resetn  in  1  synchronous, active-high reset (reset while 1).
- sclk  in  1  host SPI clock (asynchronous).
- cen  in  1  host chip enable (asynchronous).
- cs  in  2  host bank select.
- sio_in  in  4  {sio3, sio2, sio1, sio0} from pads.
- sio_out  out  4  pad output data.
- sio_oe  out  4  pad output enables; the top level builds the inout.
- mem_addr  out  24  byte address.
- mem_wdata  out  8  write byte.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe; mem_rdata is valid on the next clk.
- mem_rdata  in  8  read byte.

## Operation

- sclk, cen and cs each pass through a 2-FF synchronizer. Edge detect runs on the synchronized sclk.
- Sample on sclk rising edges. Drive on sclk falling edges. Every bit/nibble is MSB first.
- States: IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE.
- IDLE -> CMD when synchronized select asserts and cs == CS_ID. Otherwise stay in IDLE.
- CMD: shift 8 bits from sio_in[0].
  - Valid opcode for QUAD_MODE -> ADDR.
  - Any other opcode -> IGNORE, which holds until deselect.
- ADDR: 24 bits, sent as 6 quad nibbles (QUAD_MODE) or 24 single bits.
  - Write -> WDATA.
  - 0x03 -> RDATA.
  - 0xEB -> WAIT.
- At address completion on a read, pulse mem_re with mem_addr = address.
- WAIT: count WAIT_CYCLES rising edges. sio_oe stays 0. Then -> RDATA.
- RDATA:
  - sio_oe = 4'b1111 (quad) or 4'b0010 (single).
  - Each falling edge presents the next nibble/bit of the current byte.
  - At the rising edge that completes a byte: address increments by 1 and a prefetch mem_re is issued.
  - Streaming is unbounded. Address wraps 24'hFFFFFF -> 0.
- WDATA: assemble bytes from rising edges. Each complete byte pulses mem_we at the current address, then the address increments. The host sends 1, 2 or 4 bytes; the length is implied by deselect.
- Deselect (synchronized) in any state:
  - Next clk -> IDLE, sio_oe = 0.
  - A partial byte is discarded; no mem_we for it.
  - An in-flight prefetch is ignored.
- Input widths: quad samples use sio_in[3:0]; single-bit samples use sio_in[0].

## Timing

- Reset values: sio_oe = 0, sio_out = 0, mem_we = 0, mem_re = 0, mem_addr = 0, mem_wdata = 0, state IDLE, synchronizers cleared.
- Edge-to-action latency: 3 clk (2 sync + 1 register) from the pad sclk edge to a sio_out/sio_oe change or a mem strobe.
- The host keeps each sclk phase ≥ 1 host clk, so each phase is ≥ 3 responder clk. Therefore:
  - Drive data is settled before the next rising edge.
  - A prefetch issued at the address/byte-completing rising edge returns before the following falling edge.
- Output enable:
  - 0x03: enabled at the falling edge after the last address bit.
  - 0xEB: enabled at the falling edge after the last wait cycle.
  - Never during CMD, ADDR or WAIT.
- The sclk idle level is irrelevant; only edges inside a selection count.
- A rising edge and deselect seen in the same clk: deselect wins and the edge is discarded.
- Reset asserted mid-transfer: the reset values above apply on the next clk and no memory strobe is issued. After reset releases, the responder waits for a fresh select edge; a select that is already active does not start a transaction.

## Structure

- Shared package qqspi_pkg holds:
  - CMD_QUAD_WRITE = 8'h38, CMD_FAST_READ_QUAD = 8'hEB, CMD_WRITE = 8'h02, CMD_READ = 8'h03 (shared with the host).
  - The responder state encoding.
- One sub-module, qqspi_pin_sync: 2-FF synchronizers for sclk/cen/cs plus one-clk rise/fall pulses for sclk.

## Test plan

- Quad write 0x38, addr 24'h000100, wstrb 4'b1111, data 32'hDEADBEEF -> mem_we ×4, bytes DE, AD, BE, EF at 0x100..0x103; no 5th strobe.
- Quad read 0xEB, addr 24'h000100 after the previous write, 6 wait cycles -> host rdata = 32'hDEADBEEF; sio_oe = 0 through WAIT.
- Single mode (QUAD_MODE = 0): write 0x02 one byte 8'h5A at addr 24'h000003, then read 0x03 at 24'h000000 -> mem byte 3 = 5A; sio_oe = 4'b0010 only during data.
- cs = 2'b01 with CS_ID = 0, write attempt -> no mem_we, sio_oe stays 0.
- Deselect after 12 data bits of a quad write to 24'hFFFFFF -> one mem_we at 24'hFFFFFF; the partial nibble is discarded. A 4-byte read at 24'hFFFFFE returns bytes from FFFFFE, FFFFFF, 000000, 000001.
- resetn pulse mid-RDATA -> sio_oe = 0 next clk; next transaction completes normally; unknown opcode 8'h9F -> IGNORE, no strobes, no drive.
